// File: rtl/pipeline_ctrl.sv
// Pipeline stall controller: resolves IF/ID/EX stall requests into the stall
// vector, tracks the stall source, and keeps saturating stall statistics.
module pipeline_ctrl #(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic [1:0]       stall_src,
  output logic [CNT_W-1:0] if_stall_cnt,
  output logic [CNT_W-1:0] id_stall_cnt,
  output logic [CNT_W-1:0] ex_stall_cnt,
  output logic [CNT_W-1:0] burst_len,
  output logic             stall_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_IF = 2'd1,
    STALL_ID = 2'd2,
    STALL_EX = 2'd3
  } src_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] MAX_STALL_C = CNT_W'(MAX_STALL);

  src_t             eff_src;
  src_t             state;
  logic [CNT_W-1:0] burst_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Priority EX > ID > IF; the winner is the only source that gets counted.
  always_comb begin
    // NOTE: default assignment first so no path leaves eff_src unassigned (no latch).
    eff_src = RUN;
    if (stallreq_from_ex)      eff_src = STALL_EX;
    else if (stallreq_from_id) eff_src = STALL_ID;
    else if (stallreq_from_if) eff_src = STALL_IF;
  end

  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      case (eff_src)
        STALL_EX: stall = 6'b001111;
        STALL_ID: stall = 6'b000111;
        STALL_IF: stall = 6'b000011;
        default:  stall = 6'b000000;
      endcase
    end
  end

  // A stall after RUN starts a new burst; a source change mid-burst continues it.
  assign burst_next = (state == RUN) ? CNT_W'(1) : sat_inc(burst_len);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (rst) begin
      state         <= RUN;
      if_stall_cnt  <= '0;
      id_stall_cnt  <= '0;
      ex_stall_cnt  <= '0;
      burst_len     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state <= eff_src;
      if (cnt_clr) begin
        if_stall_cnt  <= '0;
        id_stall_cnt  <= '0;
        ex_stall_cnt  <= '0;
        burst_len     <= '0;
        stall_timeout <= 1'b0;
      end else begin
        case (eff_src)
          STALL_IF: if_stall_cnt <= sat_inc(if_stall_cnt);
          STALL_ID: id_stall_cnt <= sat_inc(id_stall_cnt);
          STALL_EX: ex_stall_cnt <= sat_inc(ex_stall_cnt);
          default:  ;
        endcase
        if (eff_src != RUN) begin
          burst_len <= burst_next;
          if (burst_next >= MAX_STALL_C) stall_timeout <= 1'b1;
        end
      end
    end
  end

  assign stall_src = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (default and narrow
// parameters) share stimulus; a queue scoreboard checks registered outputs.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] ifc;
    logic [63:0] idc;
    logic [63:0] exc;
    logic [63:0] burst;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, cnt_clr;
  logic [5:0]  a_stall, b_stall;
  logic [1:0]  a_src, b_src;
  logic [31:0] a_ifc, a_idc, a_exc, a_burst;
  logic [2:0]  b_ifc, b_idc, b_exc, b_burst;
  logic        a_to, b_to;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  exp_t        m[2];
  logic [63:0] lim[2];
  logic [63:0] mx[2];

  always #5 clk = ~clk;

  pipeline_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id), .stallreq_from_ex(req_ex),
    .cnt_clr(cnt_clr), .stall(a_stall), .stall_src(a_src),
    .if_stall_cnt(a_ifc), .id_stall_cnt(a_idc), .ex_stall_cnt(a_exc),
    .burst_len(a_burst), .stall_timeout(a_to)
  );

  pipeline_ctrl #(.CNT_W(3), .MAX_STALL(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id), .stallreq_from_ex(req_ex),
    .cnt_clr(cnt_clr), .stall(b_stall), .stall_src(b_src),
    .if_stall_cnt(b_ifc), .id_stall_cnt(b_idc), .ex_stall_cnt(b_exc),
    .burst_len(b_burst), .stall_timeout(b_to)
  );

  function automatic exp_t get_act(input int i);
    exp_t r;
    if (i == 0) r = '{a_src, 64'(a_ifc), 64'(a_idc), 64'(a_exc), 64'(a_burst), a_to};
    else        r = '{b_src, 64'(b_ifc), 64'(b_idc), 64'(b_exc), 64'(b_burst), b_to};
    return r;
  endfunction

  function automatic void model_reset();
    m[0] = '0;
    m[1] = '0;
  endfunction

  // Reference behaviour of one clock edge, for both parameter sets.
  function automatic void model_edge(input bit ri, input bit rd, input bit re, input bit clr);
    logic [1:0]  eff;
    logic [63:0] nb;
    eff = re ? 2'd3 : rd ? 2'd2 : ri ? 2'd1 : 2'd0;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m[i].ifc = 0; m[i].idc = 0; m[i].exc = 0; m[i].burst = 0; m[i].to = 1'b0;
      end else begin
        if (eff == 2'd1 && m[i].ifc != lim[i]) m[i].ifc++;
        if (eff == 2'd2 && m[i].idc != lim[i]) m[i].idc++;
        if (eff == 2'd3 && m[i].exc != lim[i]) m[i].exc++;
        if (eff != 2'd0) begin
          if (m[i].src == 2'd0) nb = 1;
          else nb = (m[i].burst == lim[i]) ? m[i].burst : m[i].burst + 1;
          m[i].burst = nb;
          if (nb >= mx[i]) m[i].to = 1'b1;
        end
      end
      m[i].src = eff;
    end
  endfunction

  // One cycle: drive, check the combinational stall vector, push the expected
  // post-edge state, then pop and compare it after the edge.
  task automatic step(input bit ri, input bit rd, input bit re, input bit clr);
    logic [5:0] es;
    exp_t       e, act;
    req_if = ri; req_id = rd; req_ex = re; cnt_clr = clr;
    #1;
    es = re ? 6'b001111 : rd ? 6'b000111 : ri ? 6'b000011 : 6'b000000;
    checks++;
    if (a_stall !== es) begin
      errors++;
      $display("FAIL stall_a got %b exp %b (req %b%b%b)", a_stall, es, re, rd, ri);
    end
    checks++;
    if (b_stall !== es) begin
      errors++;
      $display("FAIL stall_b got %b exp %b (req %b%b%b)", b_stall, es, re, rd, ri);
    end
    model_edge(ri, rd, re, clr);
    sb.push_back(m[0]);
    sb.push_back(m[1]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      e   = sb.pop_front();
      act = get_act(i);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL sb_dut%0d got src=%0d if=%0d id=%0d ex=%0d burst=%0d to=%b exp src=%0d if=%0d id=%0d ex=%0d burst=%0d to=%b",
                 i, act.src, act.ifc, act.idc, act.exc, act.burst, act.to,
                 e.src, e.ifc, e.idc, e.exc, e.burst, e.to);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_if = 1'b1; req_id = 1'b1; req_ex = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_stall !== 6'b0 || b_stall !== 6'b0) begin
      errors++;
      $display("FAIL reset_stall got %b/%b exp 000000", a_stall, b_stall);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (get_act(i) !== exp_t'(0)) begin
        errors++;
        $display("FAIL reset_state_dut%0d got %h exp 0", i, get_act(i));
      end
    end
  endtask

  task automatic test_priority();
    step(1, 1, 1, 0);
    checks++;
    if (a_src !== 2'd3 || a_exc !== 32'd1 || a_idc !== 32'd0 || a_ifc !== 32'd0) begin
      errors++;
      $display("FAIL priority got src=%0d ex=%0d id=%0d if=%0d exp 3 1 0 0", a_src, a_exc, a_idc, a_ifc);
    end
  endtask

  task automatic test_src_change();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++;
    if (a_burst !== 32'd5 || a_idc !== 32'd2 || a_exc !== 32'd3 || a_src !== 2'd0) begin
      errors++;
      $display("FAIL src_change got burst=%0d id=%0d ex=%0d src=%0d exp 5 2 3 0", a_burst, a_idc, a_exc, a_src);
    end
    step(0, 0, 0, 0);
    checks++;
    if (a_burst !== 32'd5) begin
      errors++;
      $display("FAIL burst_hold got %0d exp 5", a_burst);
    end
  endtask

  task automatic test_watchdog();
    step(0, 0, 0, 1);
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, 1, 0);
      checks++;
      if (b_to !== (c == 4)) begin
        errors++;
        $display("FAIL watchdog_cyc%0d got %b exp %b", c, b_to, (c == 4));
      end
    end
    step(0, 0, 0, 0);
    checks++;
    if (b_to !== 1'b1 || a_to !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_sticky got b=%b a=%b exp 1 0", b_to, a_to);
    end
    step(0, 0, 0, 1);
    checks++;
    if (b_to !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clr got %b exp 0", b_to);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 0);
    checks++;
    if (b_ifc !== 3'd7 || b_burst !== 3'd7 || a_ifc !== 32'd10 || a_burst !== 32'd10) begin
      errors++;
      $display("FAIL saturation got b_if=%0d b_burst=%0d a_if=%0d a_burst=%0d exp 7 7 10 10",
               b_ifc, b_burst, a_ifc, a_burst);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_clr_during_stall();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    checks++;
    if (a_idc !== 32'd0 || a_burst !== 32'd0 || a_src !== 2'd2) begin
      errors++;
      $display("FAIL clr_stall got id=%0d burst=%0d src=%0d exp 0 0 2", a_idc, a_burst, a_src);
    end
    step(0, 1, 0, 0);
    checks++;
    if (a_idc !== 32'd1 || a_burst !== 32'd1 || a_src !== 2'd2) begin
      errors++;
      $display("FAIL clr_resume got id=%0d burst=%0d src=%0d exp 1 1 2", a_idc, a_burst, a_src);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(0, 0, 1, 0);
    checks++;
    if (a_burst !== 32'd1 || a_exc !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_burst got burst=%0d ex=%0d exp 1 1", a_burst, a_exc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    lim[0] = 64'hFFFF_FFFF; mx[0] = 64;
    lim[1] = 64'd7;         mx[1] = 4;
    model_reset();
    test_reset();
    test_priority();
    test_src_change();
    test_watchdog();
    test_saturation();
    test_clr_during_stall();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline stall controller for the five-stage core. It drives the `stall[5:0]` vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) samples. It resolves stall requests from the IF, ID and EX stages into a single stall pattern. It also keeps saturating per-source stall statistics, tracks the current stall source in a registered state machine, and raises a sticky watchdog flag when one continuous stall exceeds a programmed length.

## Interface
Parameters:
- `CNT_W`, default 32: width of the statistics counters and the burst counter.
- `MAX_STALL`, default 64: number of consecutive stalled cycles that sets `stall_timeout`. Legal range 1 to 2^CNT_W-1.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stallreq_from_if`  in  1: IF stage waiting (instruction bus not ready).
- `stallreq_from_id`  in  1: ID stage hazard (load-use).
- `stallreq_from_ex`  in  1: EX stage multi-cycle operation (madd/msub/div).
- `cnt_clr`  in  1: synchronous clear of the counters and `stall_timeout`.
- `stall`  out  6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- `stall_src`  out  2: registered FSM state; 0 RUN, 1 STALL_IF, 2 STALL_ID, 3 STALL_EX.
- `if_stall_cnt`, `id_stall_cnt`, `ex_stall_cnt`  out  CNT_W each: cycles stalled by each source, saturating.
- `burst_len`  out  CNT_W: length of the current or most recent continuous stall, saturating.
- `stall_timeout`  out  1: sticky watchdog flag.

## Operation
- `stall` is combinational. Priority is EX > ID > IF:
  - ex request → 6'b001111
  - else id request → 6'b000111
  - else if request → 6'b000011
  - else 6'b000000
- While `rst` = 1, `stall` = 6'b000000 regardless of the request inputs.
- The winning source is the "effective source" for the cycle. Lower-priority requests that are masked do not count toward their own counters.
- FSM (`stall_src`): next state is the effective source, or RUN when no request is active. Every state can transition to every other state in one cycle.
- Statistics: each rising edge where the effective source is X increments X's counter by 1. The counter holds at all-ones (2^CNT_W-1).
- Burst tracking:
  - A stalled cycle that follows a RUN state (stall_src = 0) loads `burst_len` = 1.
  - A stalled cycle that follows a stalled state increments `burst_len`, saturating. A change of source mid-burst does not restart the burst.
  - A RUN cycle holds `burst_len` unchanged, so the last burst stays observable.
- Watchdog: on the edge where `burst_len` would become ≥ MAX_STALL, `stall_timeout` is set to 1. It stays 1 until `rst` or `cnt_clr`.
- `cnt_clr` has priority over counting:
  - On a `cnt_clr` edge, all three counters, `burst_len` and `stall_timeout` go to 0, even if a stall is active in that cycle.
  - The FSM is not affected by `cnt_clr`.
  - If the stall continues into the next cycle, counting resumes with `burst_len` = 1, because the prior state is stalled but the count was cleared to 0.
- Reset values: `stall_src` = RUN (0); all counters, `burst_len` and `stall_timeout` = 0. Reset mid-burst abandons the burst. `rst` has priority over `cnt_clr`.

## Timing
- `stall` has zero latency: requests sampled in cycle N stop the pipeline registers at the edge ending cycle N.
- `stall_src`, the counters, `burst_len` and `stall_timeout` reflect cycle N from cycle N+1 onward (one-cycle latency).
- No handshake. Requests are level signals, held by each requester for as long as it needs the stall. Single-cycle requests are legal and count as a burst of 1.
- `stall_timeout` asserts in the cycle after the MAX_STALL-th consecutive stalled cycle.

## Test plan
- Reset: hold `rst` with all three requests = 1 → `stall` = 0. After release, `stall_src` = 0, all counters 0, `stall_timeout` 0.
- Priority: assert the if, id and ex requests together for 1 cycle → `stall` = 6'b001111 that cycle. Next cycle `stall_src` = 3, `ex_stall_cnt` = 1, `id_stall_cnt` = 0, `if_stall_cnt` = 0.
- Source change mid-burst: id request for 2 cycles, then ex request for 3 cycles, then idle → `stall` = 000111, 000111, 001111×3, 000000. Final `burst_len` = 5, `id_stall_cnt` = 2, `ex_stall_cnt` = 3. `burst_len` stays 5 while idle.
- Watchdog: MAX_STALL = 4, ex request held for 4 cycles → `stall_timeout` 0 through cycle 4 and 1 from cycle 5. It stays 1 after the request drops, and `cnt_clr` returns it to 0.
- Saturation: CNT_W = 3, if request held for 10 cycles → `if_stall_cnt` and `burst_len` stop at 7.
- Clear during stall: id request held, `cnt_clr` pulsed on its 3rd cycle → counters 0 the next cycle, then `burst_len` = 1 and `id_stall_cnt` = 1 one cycle later. `stall_src` remains 2 throughout.
